// File: rtl/caf_pkg.sv
// Shared definitions for the capture sequencer: FSM state encoding and the
// width of one packed buffer word.
package caf_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    RD_OUT  = 3'd6
  } cap_state_e;

endpackage

// File: rtl/capture_counter.sv
// Saturating up-counter with synchronous clear; it stops at `limit` instead of
// wrapping, so a late enable can never alias back onto address 0.
module capture_counter #(
  parameter int          width = 4,
  parameter int unsigned limit = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] LIMIT = width'(limit);

  logic [width-1:0] count_d;
  logic [width-1:0] count_q;
  logic             at_limit;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left count_d unassigned would infer a latch.
    count_d  = count_q;
    at_limit = (count_q == LIMIT);
    if (clr) begin
      count_d = '0;
    end else if (en && !at_limit) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignment so every register samples the
  // pre-edge values no matter which order the simulator runs processes in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/capture_sequencer.sv
// Arms on a pulse, records buffer_length trigger-qualified samples into an
// external buffer, waits for every write ack, then streams the samples back out.
module capture_sequencer
  import caf_pkg::*;
#(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  input  logic signed [i_bits-1:0] s_i,
  input  logic signed [q_bits-1:0] s_q,
  input  logic                     s_valid,
  output logic [index_bits-1:0]    buf_waddr,
  output logic                     buf_wvalid,
  output logic [SAMPLE_W-1:0]      buf_wdata,
  input  logic                     buf_bvalid,
  output logic [index_bits-1:0]    buf_raddr,
  output logic                     buf_rvalid,
  output logic                     buf_rready,
  input  logic                     buf_rdvalid,
  input  logic [i_bits-1:0]        buf_i,
  input  logic [q_bits-1:0]        buf_q,
  output logic [i_bits-1:0]        m_i,
  output logic [q_bits-1:0]        m_q,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  if (i_bits + q_bits > SAMPLE_W) begin : g_bad_width
    $error("capture_sequencer: i_bits + q_bits exceeds the packed sample width");
  end

  localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);

  cap_state_e state_q, state_d;

  logic [index_bits-1:0] wr_cnt, ack_cnt, rd_cnt;
  logic                  wr_last, ack_last, rd_last;
  logic                  cnt_clr, wr_en, ack_en, rd_en;
  logic                  accept, handshake, rd_load, ack_complete;
  logic [SAMPLE_W-1:0]   wdata_pack;

  logic                  buf_wvalid_d, buf_wvalid_q;
  logic [index_bits-1:0] buf_waddr_d, buf_waddr_q;
  logic [SAMPLE_W-1:0]   buf_wdata_d, buf_wdata_q;
  logic [i_bits-1:0]     m_i_d, m_i_q;
  logic [q_bits-1:0]     m_q_d, m_q_q;
  logic                  m_valid_d, m_valid_q;
  logic                  done_d, done_q;
  logic                  acks_done_d, acks_done_q;

  // Abort gates every qualifying strobe so nothing issued in its cycle survives.
  always_comb begin
    wr_last      = (wr_cnt == LAST_IDX);
    ack_last     = (ack_cnt == LAST_IDX);
    rd_last      = (rd_cnt == LAST_IDX);
    accept       = !abort && s_valid &&
                   ((state_q == ARMED && trigger) || state_q == CAPTURE);
    handshake    = (state_q == RD_OUT) && m_valid_q && m_ready;
    rd_load      = !abort && (state_q == RD_WAIT) && buf_rdvalid;
    ack_en       = !abort && buf_bvalid && !acks_done_q &&
                   (state_q == CAPTURE || state_q == DRAIN);
    ack_complete = acks_done_q || (ack_en && ack_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm)                     state_d = ARMED;
      ARMED:   if (trigger && s_valid)      state_d = CAPTURE;
      CAPTURE: if (s_valid && wr_last)      state_d = DRAIN;
      DRAIN:   if (ack_complete)            state_d = RD_REQ;
      RD_REQ:                               state_d = RD_WAIT;
      RD_WAIT: if (buf_rdvalid)             state_d = RD_OUT;
      RD_OUT:  if (handshake)               state_d = rd_last ? IDLE : RD_REQ;
      default:                              state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    buf_rvalid = (state_q == RD_REQ);
    buf_rready = (state_q == RD_REQ);
    buf_raddr  = (state_q == RD_REQ) ? rd_cnt : '0;
    m_last     = (state_q == RD_OUT) && rd_last;
  end

  // Counters restart on every IDLE entry and while sitting in IDLE, which
  // covers both the return path and a fresh arm.
  assign cnt_clr = (state_d == IDLE) || (state_q == IDLE);
  assign wr_en   = accept;
  assign rd_en   = handshake && !rd_last && !abort;

  capture_counter #(.width(index_bits), .limit(buffer_length - 1)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (wr_en),
    .count (wr_cnt)
  );

  capture_counter #(.width(index_bits), .limit(buffer_length - 1)) u_ack_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (ack_en),
    .count (ack_cnt)
  );

  capture_counter #(.width(index_bits), .limit(buffer_length - 1)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (rd_en),
    .count (rd_cnt)
  );

  always_comb begin
    wdata_pack                   = '0;
    wdata_pack[q_bits-1:0]       = s_q;
    wdata_pack[q_bits +: i_bits] = s_i;

    buf_wvalid_d = accept;
    buf_waddr_d  = buf_waddr_q;
    buf_wdata_d  = buf_wdata_q;
    if (accept) begin
      buf_waddr_d = wr_cnt;
      buf_wdata_d = wdata_pack;
    end

    // The ack counter saturates at its last index, so this flag remembers
    // that the final ack has actually arrived.
    acks_done_d = cnt_clr ? 1'b0 : ack_complete;

    m_i_d     = m_i_q;
    m_q_d     = m_q_q;
    m_valid_d = m_valid_q;
    if (rd_load) begin
      m_i_d     = buf_i;
      m_q_d     = buf_q;
      m_valid_d = 1'b1;
    end
    if (handshake || abort) begin
      m_valid_d = 1'b0;
    end

    done_d = !abort && handshake && rd_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_wvalid_q <= 1'b0;
      buf_waddr_q  <= '0;
      buf_wdata_q  <= '0;
      m_i_q        <= '0;
      m_q_q        <= '0;
      m_valid_q    <= 1'b0;
      done_q       <= 1'b0;
      acks_done_q  <= 1'b0;
    end else begin
      buf_wvalid_q <= buf_wvalid_d;
      buf_waddr_q  <= buf_waddr_d;
      buf_wdata_q  <= buf_wdata_d;
      m_i_q        <= m_i_d;
      m_q_q        <= m_q_d;
      m_valid_q    <= m_valid_d;
      done_q       <= done_d;
      acks_done_q  <= acks_done_d;
    end
  end

  assign buf_wvalid = buf_wvalid_q;
  assign buf_waddr  = buf_waddr_q;
  assign buf_wdata  = buf_wdata_q;
  assign m_i        = m_i_q;
  assign m_q        = m_q_q;
  assign m_valid    = m_valid_q;
  assign done       = done_q;

endmodule
